// File: rtl/sub32_serial.sv
// sub32_serial: bit-serial unsigned subtractor, LSB first, with valid/ready handshakes
module sub32_serial #(
    parameter int nb_bits = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [nb_bits-1:0] a_i,
    input  logic [nb_bits-1:0] b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [nb_bits:0]   diff_o,
    output logic               busy_o
);
    localparam int cw = $clog2(nb_bits);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [nb_bits-1:0] a_q, a_d, b_q, b_d;
    logic [nb_bits:0]   diff_q, diff_d;
    logic [cw-1:0]      cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               d_bit, borrow_nxt, last;

    // State register; reset aborts any operation immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
        end
    end

    // Next state: a_q shifts right while collecting difference bits at its MSB
    always_comb begin
        d_bit      = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        last       = cnt_q == cw'(nb_bits - 1);
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        diff_d     = diff_q;
        cnt_d      = cnt_q;
        borrow_d   = borrow_q;
        case (state_q)
            IDLE: if (valid_i) begin
                state_d  = RUN;
                a_d      = a_i;
                b_d      = b_i;
                cnt_d    = '0;
                borrow_d = 1'b0;
            end
            RUN: begin
                a_d      = {d_bit, a_q[nb_bits-1:1]};
                b_d      = b_q >> 1;
                borrow_d = borrow_nxt;
                cnt_d    = last ? cnt_q : cnt_q + cw'(1);
                if (last) begin
                    state_d = DONE;
                    diff_d  = {borrow_nxt, d_bit, a_q[nb_bits-1:1]};
                end
            end
            DONE: state_d = ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = state_q == IDLE;
    assign valid_o = state_q == DONE;
    assign busy_o  = state_q == RUN;
    assign diff_o  = diff_q;
endmodule
